// File: rtl/vector_pkg.sv
// Shared types for the vector sequencer: opcodes, ALU op codes, control
// bundle and sequencer state.
package vector_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned ALU_W = 2;

  typedef enum logic [OPC_W-1:0] {
    G3_VADD = 5'b10000,
    G3_VSUB = 5'b10001,
    G3_VMUL = 5'b10010,
    G3_VLDR = 5'b10100,
    G3_VSTR = 5'b10101
  } vec_opcode_e;

  localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_W-1:0] ALU_MUL = 2'b10;
  localparam logic [ALU_W-1:0] ALU_MEM = 2'b11;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             dst;
    logic             rd;
    logic             wr;
    logic             vwr;
    logic             s1;
    logic             s2;
  } vec_ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Decode-side handshake plus per-beat datapath control bundle.
interface vector_sequencer_if
  import vector_pkg::*;
#(
  parameter int unsigned BW = 2
);
  logic             instr_valid;
  logic             instr_ready;
  logic [OPC_W-1:0] opcode;
  logic             mem_ready;
  logic             beat_valid;
  logic [BW-1:0]    beat_idx;
  logic [ALU_W-1:0] alu_vectorial;
  logic             vect_dst;
  logic             vector_read;
  logic             mem_write_vector;
  logic             vect_write;
  logic             vect_src1;
  logic             vect_src2;
  logic             busy;
  logic             done;
  logic             illegal_op;

  modport master (
    output instr_valid, opcode, mem_ready,
    input  instr_ready, beat_valid, beat_idx, alu_vectorial, vect_dst,
           vector_read, mem_write_vector, vect_write, vect_src1, vect_src2,
           busy, done, illegal_op
  );

  modport slave (
    input  instr_valid, opcode, mem_ready,
    output instr_ready, beat_valid, beat_idx, alu_vectorial, vect_dst,
           vector_read, mem_write_vector, vect_write, vect_src1, vect_src2,
           busy, done, illegal_op
  );
endinterface

// File: rtl/vector_ctrl_decode.sv
// Combinational opcode decoder: control bundle plus legal flag.
module vector_ctrl_decode
  import vector_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output vec_ctrl_t        ctrl,
  output logic             legal
);

  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    case (opcode)
      G3_VADD: begin ctrl = '{alu: ALU_ADD, dst: 1'b1, rd: 1'b0, wr: 1'b0, vwr: 1'b0, s1: 1'b1, s2: 1'b1}; legal = 1'b1; end
      G3_VSUB: begin ctrl = '{alu: ALU_SUB, dst: 1'b1, rd: 1'b0, wr: 1'b0, vwr: 1'b0, s1: 1'b1, s2: 1'b1}; legal = 1'b1; end
      G3_VMUL: begin ctrl = '{alu: ALU_MUL, dst: 1'b1, rd: 1'b0, wr: 1'b0, vwr: 1'b0, s1: 1'b1, s2: 1'b1}; legal = 1'b1; end
      G3_VLDR: begin ctrl = '{alu: ALU_MEM, dst: 1'b1, rd: 1'b1, wr: 1'b0, vwr: 1'b1, s1: 1'b1, s2: 1'b0}; legal = 1'b1; end
      G3_VSTR: begin ctrl = '{alu: ALU_MEM, dst: 1'b1, rd: 1'b0, wr: 1'b1, vwr: 1'b0, s1: 1'b1, s2: 1'b0}; legal = 1'b1; end
      default: begin ctrl = '0; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/vector_sequencer.sv
// Splits one vector opcode into VLEN/LANES beats of registered datapath
// controls, with multiply wait cycles and memory back-pressure stalls.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned VLEN     = 16,
  parameter int unsigned LANES    = 4,
  parameter int unsigned MUL_WAIT = 2
)(
  input  logic               clk,
  input  logic               rst,
  vector_sequencer_if.slave  bus
);

  localparam int unsigned BEATS = VLEN / LANES;
  localparam int unsigned BW    = width_of(BEATS);
  localparam int unsigned WW    = width_of(MUL_WAIT + 1);

  seq_state_e    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wait_q, wait_d;
  vec_ctrl_t     op_q, op_d, ctrl_q, ctrl_d, dec_ctrl;
  logic          dec_legal;
  logic          valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;
  logic          done_q, done_d, illegal_q, illegal_d;
  logic          last_beat, is_mem, is_mul, beat_ok;

  vector_ctrl_decode u_decode (
    .opcode (bus.opcode),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal)
  );

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign is_mem    = op_q.rd | op_q.wr;
  assign is_mul    = (op_q.alu == ALU_MUL) && !is_mem;
  assign beat_ok   = !is_mem || bus.mem_ready;

  // Next state; outputs are precomputed from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          if (dec_legal) begin
            op_d    = dec_ctrl;
            beat_d  = '0;
            state_d = S_ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (beat_ok) begin
          if (is_mul && (MUL_WAIT > 0)) begin
            wait_d  = '0;
            state_d = S_WAIT;
          end else if (last_beat) begin
            state_d = S_DONE;
          end else begin
            beat_d = BW'(beat_q + 1'b1);
          end
        end
      end
      S_WAIT: begin
        if (wait_q == WW'(MUL_WAIT - 1)) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            beat_d  = BW'(beat_q + 1'b1);
            state_d = S_ISSUE;
          end
        end else begin
          wait_d = WW'(wait_q + 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_ISSUE);
    ctrl_d  = valid_d ? op_d : '0;
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      wait_q    <= '0;
      op_q      <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.instr_ready      = ready_q;
  assign bus.busy             = busy_q;
  assign bus.beat_valid       = valid_q;
  assign bus.beat_idx         = beat_q;
  assign bus.alu_vectorial    = ctrl_q.alu;
  assign bus.vect_dst         = ctrl_q.dst;
  assign bus.vector_read      = ctrl_q.rd;
  assign bus.mem_write_vector = ctrl_q.wr;
  assign bus.vect_write       = ctrl_q.vwr;
  assign bus.vect_src1        = ctrl_q.s1;
  assign bus.vect_src2        = ctrl_q.s2;
  assign bus.done             = done_q;
  assign bus.illegal_op       = illegal_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Cycle-accurate scoreboard bench for vector_sequencer (VLEN=16, LANES=4, MUL_WAIT=2).
module tb_vector_sequencer;

  typedef struct packed {
    logic       bv;
    logic [1:0] idx;
    logic [7:0] ctrl;   // {alu, dst, rd, wr, vwr, s1, s2}
    logic       done;
    logic       ready;
    logic       busy;
    logic       ill;
  } obs_t;

  localparam logic [7:0] C_VADD = 8'b00_100011;
  localparam logic [7:0] C_VSUB = 8'b01_100011;
  localparam logic [7:0] C_VMUL = 8'b10_100011;
  localparam logic [7:0] C_VLDR = 8'b11_110110;
  localparam logic [7:0] C_VSTR = 8'b11_101010;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;
  obs_t exp_q[$];

  vector_sequencer_if #(.BW(2)) vif ();

  vector_sequencer #(.VLEN(16), .LANES(4), .MUL_WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.bv    = vif.beat_valid;
    o.idx   = vif.beat_idx;
    o.ctrl  = {vif.alu_vectorial, vif.vect_dst, vif.vector_read, vif.mem_write_vector,
               vif.vect_write, vif.vect_src1, vif.vect_src2};
    o.done  = vif.done;
    o.ready = vif.instr_ready;
    o.busy  = vif.busy;
    o.ill   = vif.illegal_op;
    return o;
  endfunction

  task automatic push(input logic bv, input logic [1:0] idx, input logic [7:0] ctrl,
                      input logic done, input logic ready, input logic ill);
    obs_t e;
    e.bv = bv; e.idx = idx; e.ctrl = ctrl; e.done = done;
    e.ready = ready; e.busy = !ready; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic start_op(input logic [4:0] op);
    @(negedge clk);
    vif.instr_valid = 1'b1;
    vif.opcode      = op;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    vif.instr_valid = 1'b0;
    vif.opcode      = 5'b0;
    vif.mem_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = sample();
    e = '{bv: 1'b0, idx: 2'd0, ctrl: 8'h00, done: 1'b0, ready: 1'b1, busy: 1'b0, ill: 1'b0};
    n_checks++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", o, e);
    end
    rst = 1'b0;
  endtask

  task automatic test_vadd();
    obs_t o, e;
    int   c = 0;
    for (int i = 0; i < 4; i++) push(1'b1, 2'(i), C_VADD, 1'b0, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    start_op(5'b10000);
    while (exp_q.size() > 0) begin
      @(negedge clk); c++;
      vif.instr_valid = 1'b0;
      o = sample(); e = exp_q.pop_front();
      if (!e.bv) o.idx = e.idx;
      n_checks++;
      if (o !== e) begin n_bad++; $display("FAIL vadd cycle %0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_vmul();
    obs_t o, e;
    int   c = 0;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 2'(i), C_VMUL, 1'b0, 1'b0, 1'b0);
      push(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      push(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    push(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    vif.mem_ready = 1'b0;   // must be ignored for non-memory ops
    start_op(5'b10010);
    while (exp_q.size() > 0) begin
      @(negedge clk); c++;
      vif.instr_valid = 1'b0;
      o = sample(); e = exp_q.pop_front();
      if (!e.bv) o.idx = e.idx;
      n_checks++;
      if (o !== e) begin n_bad++; $display("FAIL vmul cycle %0d: got %h want %h", c, o, e); end
    end
    vif.mem_ready = 1'b1;
  endtask

  task automatic test_vldr_stall();
    obs_t o, e;
    int   c = 0;
    push(1'b1, 2'd0, C_VLDR, 1'b0, 1'b0, 1'b0);
    push(1'b1, 2'd1, C_VLDR, 1'b0, 1'b0, 1'b0);
    push(1'b1, 2'd1, C_VLDR, 1'b0, 1'b0, 1'b0);
    push(1'b1, 2'd1, C_VLDR, 1'b0, 1'b0, 1'b0);
    push(1'b1, 2'd2, C_VLDR, 1'b0, 1'b0, 1'b0);
    push(1'b1, 2'd3, C_VLDR, 1'b0, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    start_op(5'b10100);
    while (exp_q.size() > 0) begin
      @(negedge clk); c++;
      vif.instr_valid = 1'b0;
      o = sample(); e = exp_q.pop_front();
      if (!e.bv) o.idx = e.idx;
      n_checks++;
      if (o !== e) begin n_bad++; $display("FAIL vldr cycle %0d: got %h want %h", c, o, e); end
      vif.mem_ready = !((c == 2) || (c == 3));
    end
    vif.mem_ready = 1'b1;
  endtask

  task automatic test_vstr();
    obs_t o, e;
    int   c = 0;
    for (int i = 0; i < 4; i++) push(1'b1, 2'(i), C_VSTR, 1'b0, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    start_op(5'b10101);
    while (exp_q.size() > 0) begin
      @(negedge clk); c++;
      vif.instr_valid = 1'b0;
      o = sample(); e = exp_q.pop_front();
      if (!e.bv) o.idx = e.idx;
      n_checks++;
      if (o !== e) begin n_bad++; $display("FAIL vstr cycle %0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_illegal();
    obs_t       o, e;
    logic [4:0] codes [3] = '{5'b10011, 5'b00000, 5'b11111};
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
      push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      start_op(codes[k]);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        vif.instr_valid = 1'b0;
        o = sample(); e = exp_q.pop_front();
        o.idx = e.idx;
        n_checks++;
        if (o !== e) begin n_bad++; $display("FAIL illegal op=%b: got %h want %h", codes[k], o, e); end
      end
    end
  endtask

  task automatic test_reset_midop();
    obs_t o, e;
    int   c = 0;
    push(1'b1, 2'd0, C_VADD, 1'b0, 1'b0, 1'b0);
    push(1'b1, 2'd1, C_VADD, 1'b0, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 2'(i), C_VSUB, 1'b0, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    push(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    start_op(5'b10000);
    while (exp_q.size() > 0) begin
      @(negedge clk); c++;
      vif.instr_valid = 1'b0;
      o = sample(); e = exp_q.pop_front();
      if (!e.bv) o.idx = e.idx;
      n_checks++;
      if (o !== e) begin n_bad++; $display("FAIL reset_midop cycle %0d: got %h want %h", c, o, e); end
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        vif.instr_valid = 1'b1;
        vif.opcode      = 5'b10001;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    test_reset();
    test_vadd();
    test_vmul();
    test_vldr_stall();
    test_vstr();
    test_illegal();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Multi-beat vector control unit.
- Accepts one 5-bit vector opcode per handshake and splits a VLEN-element vector op into VLEN/LANES beats.
- Drives per-beat datapath controls (ALU op, register-file and memory enables) plus a beat index.
- Sits between the decode stage and the vector register file, vector ALU and vector memory port.
- Adds multiply-latency waits, memory back-pressure stalls and illegal-opcode flagging over the single-cycle combinational decoder.

Parameters:
- VLEN, 16, elements per vector; must be a multiple of LANES.
- LANES, 4, elements processed per beat.
- MUL_WAIT, 2, idle cycles inserted after every VMUL beat (0 = back-to-back).
- Derived: BEATS = VLEN/LANES; BW = max(1, $clog2(BEATS)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  opcode presented.
- instr_ready  out  1  sequencer can accept.
- opcode  in  5  vector opcode.
- mem_ready  in  1  memory accepts/returns the current VLDR/VSTR beat.
- beat_valid  out  1  controls below are live this cycle.
- beat_idx  out  BW  current beat number.
- alu_vectorial  out  2  vector ALU op.
- vect_dst  out  1  destination is a vector register.
- vector_read  out  1  memory read enable.
- mem_write_vector  out  1  memory write enable.
- vect_write  out  1  vector register-file write from memory.
- vect_src1  out  1  source 1 is a vector register.
- vect_src2  out  1  source 2 is a vector register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- illegal_op  out  1  one-cycle pulse on rejected opcode.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset:
  - state=IDLE, beat_idx=0.
  - All outputs 0 except instr_ready=1.
  - Reset mid-operation aborts at the next edge with no done pulse.
- Opcode/control table (alu, dst, rd, wr, vwr, s1, s2):
  - VADD 10000: 00,1,0,0,0,1,1.
  - VSUB 10001: 01,1,0,0,0,1,1.
  - VMUL 10010: 10,1,0,0,0,1,1.
  - VLDR 10100: 11,1,1,0,1,1,0.
  - VSTR 10101: 11,1,0,1,0,1,0.
  - Every other code is illegal.
- Control outputs are 0 (never X) whenever beat_valid=0.
- instr_ready = (state==IDLE); busy = !instr_ready.
- States:
  - IDLE: on instr_valid&&instr_ready, latch opcode.
    - Legal: go to ISSUE, beat_idx=0.
    - Illegal: illegal_op=1 next cycle, stay IDLE, no beats.
  - ISSUE: beat_valid=1, controls from latched opcode. Beat completes:
    - VADD/VSUB: every cycle.
    - VMUL: every cycle, then go to WAIT if MUL_WAIT>0.
    - VLDR/VSTR: only in a cycle with mem_ready=1; otherwise hold beat_idx and all controls (stall).
  - On beat completion: if beat_idx==BEATS-1 go to DONE (VMUL goes via WAIT first), else increment beat_idx.
  - mem_ready is ignored for non-memory ops.
  - WAIT: MUL_WAIT cycles with beat_valid=0, then ISSUE with the next beat, or DONE after the last beat.
  - DONE: done=1 for one cycle, instr_ready=0, then IDLE.
- Latency: opcode accepted at edge 0; beats in cycles 1..BEATS; done in cycle BEATS+1 (no stalls/waits); ready in cycle BEATS+2.
- beat_idx never wraps mid-operation; it resets to 0 on each accept.

Decomposition:
- Shared package vector_pkg holds:
  - opcode enum (G3_VADD..G3_VSTR).
  - ALU op constants.
  - packed control struct (7 fields).
  - sequencer state enum.
- Sub-module vector_ctrl_decode: combinational opcode -> control struct + legal flag; no clock.

Test Plan:
- Reset then VADD (10000), VLEN=16, LANES=4 -> beat_valid cycles 1-4, beat_idx 0,1,2,3, alu_vectorial=00, vect_src2=1; done in cycle 5; instr_ready=1 in cycle 6.
- VMUL, MUL_WAIT=2 -> beats in cycles 1,4,7,10 with alu=10; beat_valid=0 in between; done in cycle 13.
- VLDR with mem_ready low in cycles 2-3 -> beat_idx holds at 1 through cycles 2-4 with vector_read=1, vect_write=1; beats end in cycle 6; done in cycle 7.
- VSTR with mem_ready=1 -> mem_write_vector=1, vect_write=0, vect_src2=0 for 4 beats.
- opcode 10011 -> illegal_op pulse in cycle 1, no beat_valid, instr_ready remains 1.
- rst asserted in cycle 2 of VADD -> cycle 3: IDLE, all controls 0, no done; a new VSUB is accepted immediately and runs cleanly.
